// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg: shared state enum, default width, counter sizing and full-subtractor equations
package serial_subtractor_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
    localparam int SUB_WIDTH = 8;
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction
    function automatic logic sub_d(input logic a, input logic b, input logic br);
        return a ^ b ^ br;
    endfunction
    function automatic logic sub_bo(input logic a, input logic b, input logic br);
        return (~a & b) | (~(a ^ b) & br);
    endfunction
endpackage

// File: rtl/serial_subtractor_cell.sv
// full_sub_cell: combinational 1-bit full subtractor (d = a - b - bin, bout = borrow)
module full_sub_cell
    import serial_subtractor_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = sub_d(a, b, bin);
    assign bout = sub_bo(a, b, bin);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: LSB-first bit-serial a - b - bin over WIDTH cycles with one full-subtractor cell.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
    output logic             ovf,
`endif
    output logic             bout
);
    localparam int CW = cnt_width(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d, b_sr_q, b_sr_d, diff_sr_q, diff_sr_d, diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d, busy_q, busy_d, done_q, done_d, bout_q, bout_d;
    logic             cell_d, cell_bo;
`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb_q, a_msb_d, b_msb_q, b_msb_d, ovf_q, ovf_d;
`endif

    full_sub_cell u_cell (.a(a_sr_q[0]), .b(b_sr_q[0]), .bin(br_q), .d(cell_d), .bout(cell_bo));

    always_comb begin
        state_d   = state_q;
        a_sr_d    = a_sr_q;
        b_sr_d    = b_sr_q;
        diff_sr_d = diff_sr_q;
        diff_d    = diff_q;
        cnt_d     = cnt_q;
        br_d      = br_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        bout_d    = bout_q;
`ifdef SERIAL_SUB_OVF_EN
        a_msb_d   = a_msb_q;
        b_msb_d   = b_msb_q;
        ovf_d     = ovf_q;
`endif
        if (state_q == IDLE && start) begin
            state_d = RUN;
            a_sr_d  = a;
            b_sr_d  = b;
            br_d    = bin;
            cnt_d   = '0;
            busy_d  = 1'b1;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_d = a[WIDTH-1];
            b_msb_d = b[WIDTH-1];
`endif
        end else if (state_q == RUN) begin
            a_sr_d               = a_sr_q >> 1;
            b_sr_d               = b_sr_q >> 1;
            diff_sr_d            = diff_sr_q >> 1;
            diff_sr_d[WIDTH-1]   = cell_d;
            br_d                 = cell_bo;
            cnt_d                = cnt_q + CW'(1);
            // Publish on the last bit so diff/bout are already valid while done is high
            if (cnt_q == CW'(WIDTH - 1)) begin
                state_d = DONE;
                done_d  = 1'b1;
                diff_d  = diff_sr_d;
                bout_d  = cell_bo;
`ifdef SERIAL_SUB_OVF_EN
                ovf_d   = (a_msb_q ^ b_msb_q) & (a_msb_q ^ cell_d);
`endif
            end
        end else if (state_q == DONE) begin
            state_d = IDLE;
            busy_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            a_sr_q    <= '0;
            b_sr_q    <= '0;
            diff_sr_q <= '0;
            diff_q    <= '0;
            cnt_q     <= '0;
            br_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bout_q    <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q   <= 1'b0;
            b_msb_q   <= 1'b0;
            ovf_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            a_sr_q    <= a_sr_d;
            b_sr_q    <= b_sr_d;
            diff_sr_q <= diff_sr_d;
            diff_q    <= diff_d;
            cnt_q     <= cnt_d;
            br_q      <= br_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            bout_q    <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q   <= a_msb_d;
            b_msb_q   <= b_msb_d;
            ovf_q     <= ovf_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf  = ovf_q;
`endif
endmodule
